gauss_blur_3x3: RTL and testbench

Streaming 3x3 Gaussian smoothing stage that sits directly downstream of `top_contrast_stretching`. It consumes that block's raster-order pixel stream and applies the kernel [1 2 1; 2 4 2; 1 2 1]/16 with two internal line buffers. It emits one filtered pixel per accepted input, with border pixels passed through unfiltered. After the frame it flushes itself and signals `done_o_gauss_blur`.

---
 rtl/gauss_blur_pkg.sv | 14 +
 rtl/gb_line_buffer.sv | 34 +++
 rtl/gauss_blur_3x3.sv | 150 +++++++++++++++
 tb/tb_gauss_blur_3x3.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_blur_pkg.sv
// Shared types and constants for the 3x3 Gaussian smoothing stage.
package gauss_blur_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } gb_state_t;

  localparam int GB_ROUND = 8;

endpackage

// File: rtl/gb_line_buffer.sv
// One-row delay line: circular single-port RAM, old word read out before the new one lands.
module gb_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 320
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (shift) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/gauss_blur_3x3.sv
// Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16), border pixels passed through.
module gauss_blur_3x3
  import gauss_blur_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk_i_gauss_blur,
  input  logic                  rstn_i_gauss_blur,
  input  logic                  en_i_gauss_blur,
  input  logic                  valid_i_gauss_blur,
  input  logic [DATA_WIDTH-1:0] data_i_gauss_blur,
  output logic [DATA_WIDTH-1:0] data_o_gauss_blur,
  output logic                  valid_o_gauss_blur,
  output logic                  done_o_gauss_blur,
  output gb_state_t             state_gauss_blur
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int IN_W  = $clog2(N);
  localparam int FL_W  = COL_W + 1;
  localparam int SUM_W = DATA_WIDTH + 4;

  logic clk, rstn, en;
  assign clk  = clk_i_gauss_blur;
  assign rstn = rstn_i_gauss_blur;
  assign en   = en_i_gauss_blur;

  gb_state_t state_q, state_d;
  logic [IN_W-1:0]  in_cnt;
  logic [FL_W-1:0]  fl_cnt;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;

  logic [DATA_WIDTH-1:0] win [3][3];
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out, pix_in;

  logic w_valid, w_border, w_last;
  logic s_valid, s_border, s_last;
  logic [DATA_WIDTH-1:0] s_centre;
  logic [SUM_W-1:0]      sum, s_sum, rnd;

  logic accept, flush_step, shift, emit, at_border, at_last;

  assign accept     = en && valid_i_gauss_blur && (state_q == FILL || state_q == RUN);
  assign flush_step = en && (state_q == FLUSH);
  assign shift      = accept || flush_step;
  assign emit       = (accept && state_q == RUN) || flush_step;
  assign pix_in     = flush_step ? '0 : data_i_gauss_blur;

  // Border is judged by the position of the pixel being emitted, not the one arriving.
  assign at_border = (out_row == '0) || (out_row == ROW_W'(IMG_HEIGHT - 1)) ||
                     (out_col == '0) || (out_col == COL_W'(IMG_WIDTH - 1));
  assign at_last   = (out_row == ROW_W'(IMG_HEIGHT - 1)) && (out_col == COL_W'(IMG_WIDTH - 1));

  assign state_gauss_blur = state_q;

  gb_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .rstn(rstn), .shift(shift), .din(pix_in), .dout(lb0_out)
  );

  gb_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .rstn(rstn), .shift(shift), .din(lb0_out), .dout(lb1_out)
  );

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (accept && in_cnt == IN_W'(IMG_WIDTH)) state_d = RUN;
        RUN:     if (accept && in_cnt == IN_W'(N - 1)) state_d = FLUSH;
        FLUSH:   if (fl_cnt == FL_W'(IMG_WIDTH)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Row 2 is the newest row, column 2 the newest column; win[1][1] is the centre.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[2][2] <= pix_in;
      win[1][2] <= lb0_out;
      win[0][2] <= lb1_out;
    end
  end

  assign sum = (SUM_W'(win[0][0]) + SUM_W'(win[0][2]) + SUM_W'(win[2][0]) + SUM_W'(win[2][2]))
             + ((SUM_W'(win[0][1]) + SUM_W'(win[1][0]) + SUM_W'(win[1][2]) + SUM_W'(win[2][1])) << 1)
             + (SUM_W'(win[1][1]) << 2);
  assign rnd = s_sum + SUM_W'(GB_ROUND);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_cnt <= '0; fl_cnt <= '0; out_col <= '0; out_row <= '0;
      w_valid <= 1'b0; w_border <= 1'b0; w_last <= 1'b0;
      s_valid <= 1'b0; s_border <= 1'b0; s_last <= 1'b0;
      s_centre <= '0; s_sum <= '0;
      data_o_gauss_blur <= '0; valid_o_gauss_blur <= 1'b0; done_o_gauss_blur <= 1'b0;
    end else if (!en) begin
      in_cnt <= '0; fl_cnt <= '0; out_col <= '0; out_row <= '0;
      w_valid <= 1'b0; s_valid <= 1'b0;
      valid_o_gauss_blur <= 1'b0; done_o_gauss_blur <= 1'b0;
    end else begin
      if (accept)     in_cnt <= in_cnt + IN_W'(1);
      if (flush_step) fl_cnt <= fl_cnt + FL_W'(1);
      if (emit) begin
        if (out_col == COL_W'(IMG_WIDTH - 1)) begin
          out_col <= '0;
          out_row <= out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
      w_valid  <= emit;
      w_border <= at_border;
      w_last   <= at_last;

      s_valid  <= w_valid;
      s_border <= w_border;
      s_last   <= w_last;
      s_centre <= win[1][1];
      s_sum    <= sum;

      valid_o_gauss_blur <= s_valid;
      if (s_valid) data_o_gauss_blur <= s_border ? s_centre : rnd[SUM_W-1:4];
      if (s_valid && s_last) done_o_gauss_blur <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// Bench for gauss_blur_3x3 on an 8x6 frame: reference blur model plus cycle-accurate output timing.
module tb_gauss_blur_3x3;
  import gauss_blur_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, en, valid_i, valid_o, done_o;
  logic [DW-1:0] data_i, data_o;
  gb_state_t     st;

  gauss_blur_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i_gauss_blur  (clk),
    .rstn_i_gauss_blur (rstn),
    .en_i_gauss_blur   (en),
    .valid_i_gauss_blur(valid_i),
    .data_i_gauss_blur (data_i),
    .data_o_gauss_blur (data_o),
    .valid_o_gauss_blur(valid_o),
    .done_o_gauss_blur (done_o),
    .state_gauss_blur  (st)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got_v[$];
  int            got_t[$];
  int            acc_t[$];
  int            done_t;
  logic [DW-1:0] exp_q[$];
  int            img[N];
  int            n_cmp = 0;
  int            n_err = 0;

  always @(negedge clk) begin
    if (valid_o) begin
      got_v.push_back(data_o);
      got_t.push_back(cyc);
    end
    if (done_o && done_t < 0) done_t = cyc;
  end

  // Reference: weight of neighbour (dr,dc) is (2-|dr|)*(2-|dc|); borders copy the input.
  function automatic void build_exp();
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          exp_q.push_back(DW'(img[r * W + c]));
        end else begin
          int s;
          s = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              s += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * img[(r + dr) * W + c + dc];
          exp_q.push_back(DW'((s + 8) / 16));
        end
      end
    end
  endfunction

  function automatic void clear_obs();
    got_v.delete();
    got_t.delete();
    acc_t.delete();
    done_t = -1;
  endfunction

  // mode 0: continuous, 1: valid toggling 1,0,1,0, 2: random gaps
  task automatic run_frame(input int mode, input string name);
    int bound;
    int t_last;
    int want_t;
    build_exp();
    clear_obs();
    @(negedge clk); en = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    for (int p = 0; p < N; p++) begin
      valid_i = 1'b1; data_i = DW'(img[p]);
      acc_t.push_back(cyc + 1);
      @(negedge clk);
      if (mode == 1) begin
        valid_i = 1'b0; data_i = DW'($urandom);
        @(negedge clk);
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          valid_i = 1'b0; data_i = DW'($urandom);
          @(negedge clk);
        end
      end
    end
    // valid_i stays high with junk through FLUSH and DONE; it must be ignored
    valid_i = 1'b1;
    bound = 0;
    while (!done_o && bound < 100) begin
      data_i = DW'($urandom);
      @(negedge clk);
      bound++;
    end
    n_cmp++;
    if (!done_o) begin
      n_err++;
      $display("FAIL %s done_timeout: done_o=%0b after %0d cycles, want 1", name, done_o, bound);
    end
    repeat (4) begin data_i = DW'($urandom); @(negedge clk); end

    n_cmp++;
    if (got_v.size() != N) begin
      n_err++;
      $display("FAIL %s out_count: got %0d want %0d", name, got_v.size(), N);
    end
    t_last = acc_t[N - 1];
    for (int j = 0; j < N && j < got_v.size(); j++) begin
      want_t = (j < N - W - 1) ? acc_t[W + 1 + j] + 2 : t_last + 3 + (j - (N - W - 1));
      n_cmp++;
      if (got_v[j] !== exp_q[j]) begin
        n_err++;
        $display("FAIL %s pixel(%0d,%0d): got %0d want %0d", name, j / W, j % W, got_v[j], exp_q[j]);
      end
      n_cmp++;
      if (got_t[j] != want_t) begin
        n_err++;
        $display("FAIL %s out_time[%0d]: got cycle %0d want %0d", name, j, got_t[j], want_t);
      end
    end
    n_cmp++;
    if (done_t != t_last + W + 3) begin
      n_err++;
      $display("FAIL %s done_rise: got cycle %0d want %0d", name, done_t, t_last + W + 3);
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_held: got %0b want 1", name, done_o);
    end
    en = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || st !== IDLE) begin
      n_err++;
      $display("FAIL %s en_drop: done_o=%0b state=%0d want done_o=0 state=%0d", name, done_o, st, IDLE);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; valid_i = 1'b1; data_i = DW'($urandom);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data_o !== '0 || valid_o !== 1'b0 || done_o !== 1'b0 || st !== IDLE) begin
      n_err++;
      $display("FAIL reset: data_o=%0d valid_o=%0b done_o=%0b state=%0d want 0/0/0/%0d",
               data_o, valid_o, done_o, st, IDLE);
    end
    rstn = 1'b1; en = 1'b0; valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constant();
    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame(0, "constant");
  endtask

  task automatic test_impulse();
    for (int i = 0; i < N; i++) img[i] = 0;
    img[2 * W + 3] = 255;
    run_frame(0, "impulse");
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) img[i] = (i / W) * 8 + (i % W);
    run_frame(0, "ramp");
  endtask

  task automatic test_toggle();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    run_frame(1, "toggle");
  endtask

  task automatic test_abort();
    int d;
    int want_n;
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    build_exp();
    clear_obs();
    @(negedge clk); en = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 20; p++) begin
      valid_i = 1'b1; data_i = DW'(img[p]);
      acc_t.push_back(cyc + 1);
      @(negedge clk);
    end
    en = 1'b0; valid_i = 1'b0;
    d = cyc + 1;
    repeat (6) @(negedge clk);
    want_n = 0;
    for (int j = W + 1; j < 20; j++) if (acc_t[j] + 2 < d) want_n++;
    n_cmp++;
    if (got_v.size() != want_n) begin
      n_err++;
      $display("FAIL abort out_count: got %0d want %0d", got_v.size(), want_n);
    end
    for (int j = 0; j < got_v.size(); j++) begin
      n_cmp++;
      if (got_t[j] >= d || got_v[j] !== exp_q[j]) begin
        n_err++;
        $display("FAIL abort out[%0d]: got %0d at cycle %0d want %0d before cycle %0d",
                 j, got_v[j], got_t[j], exp_q[j], d);
      end
    end
    n_cmp++;
    if (st !== IDLE || valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort idle: state=%0d valid_o=%0b done_o=%0b want %0d/0/0", st, valid_o, done_o, IDLE);
    end
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    run_frame(0, "after_abort");
  endtask

  task automatic test_random_gaps();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      run_frame(2, "random_gaps");
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; valid_i = 1'b0; data_i = '0;
    test_reset();
    test_constant();
    test_impulse();
    test_ramp();
    test_toggle();
    test_abort();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
